// File: rtl/hv_fold_serializer_pkg.sv
// Fold sizing shared with the folded associative memory,
// plus the serializer FSM state encoding.
package hv_fold_serializer_pkg;

  localparam int DEF_NUM_FOLDS       = 10;
  localparam int DEF_NUM_FOLDS_WIDTH = 4;
  localparam int DEF_FOLD_WIDTH      = 200;
  localparam int DEF_HV_WIDTH        = DEF_NUM_FOLDS * DEF_FOLD_WIDTH;
  localparam int DEF_HOLD_CYCLES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_HOLD
  } fold_state_e;

endpackage

// File: rtl/hv_fold_serializer_if.sv
// Query-in / fold-out handshake bundle of the fold serializer.
// slave = serializer side, master = encoder/consumer side.
interface hv_fold_serializer_if #(
  parameter int HV_WIDTH        = hv_fold_serializer_pkg::DEF_HV_WIDTH,
  parameter int FOLD_WIDTH      = hv_fold_serializer_pkg::DEF_FOLD_WIDTH,
  parameter int NUM_FOLDS_WIDTH = hv_fold_serializer_pkg::DEF_NUM_FOLDS_WIDTH
);

  logic                       hvin_valid;
  logic                       hvin_ready;
  logic [HV_WIDTH-1:0]        hvin;
  logic                       hvout_valid;
  logic                       hvout_ready;
  logic [FOLD_WIDTH-1:0]      hvout;
  logic                       hvout_last;
  logic [NUM_FOLDS_WIDTH-1:0] fold_idx;

  modport slave (
    input  hvin_valid, hvin, hvout_ready,
    output hvin_ready, hvout_valid, hvout,
    output hvout_last, fold_idx
  );

  modport master (
    output hvin_valid, hvin, hvout_ready,
    input  hvin_ready, hvout_valid, hvout,
    input  hvout_last, fold_idx
  );

endinterface

// File: rtl/hv_fold_serializer_pingpong_buffer.sv
// Two-slot ping-pong query store with a fold-select read port.
// Ready is derived from the registered count only.
module hv_pingpong_buffer
  import hv_fold_serializer_pkg::*;
#(
  parameter int NUM_FOLDS_WIDTH = DEF_NUM_FOLDS_WIDTH,
  parameter int FOLD_WIDTH      = DEF_FOLD_WIDTH,
  parameter int HV_WIDTH        = DEF_HV_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [HV_WIDTH-1:0]        wr_data_i,
  input  logic                       rel_i,
  input  logic                       rd_slot_i,
  input  logic [NUM_FOLDS_WIDTH-1:0] rd_fold_i,
  output logic [FOLD_WIDTH-1:0]      rd_data_o,
  output logic                       rd_ptr_o,
  output logic [1:0]                 count_o,
  output logic                       ready_o
);

  logic [HV_WIDTH-1:0] slot_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ wr_en_i;
    rd_ptr_d = rd_ptr_q ^ rel_i;
    count_d  = count_q + {1'b0, wr_en_i}
                       - {1'b0, rel_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data slots carry no reset; count alone marks them valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) slot_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o =
    slot_q[rd_slot_i][int'(rd_fold_i)*FOLD_WIDTH +: FOLD_WIDTH];
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign ready_o   = (count_q != 2'd2);

endmodule

// File: rtl/hv_fold_serializer.sv
// Serializes buffered query hypervectors into folds, highest
// fold first, freezing each fold for a hold window after use.
module hv_fold_serializer
  import hv_fold_serializer_pkg::*;
#(
  parameter int NUM_FOLDS       = DEF_NUM_FOLDS,
  parameter int NUM_FOLDS_WIDTH = DEF_NUM_FOLDS_WIDTH,
  parameter int FOLD_WIDTH      = DEF_FOLD_WIDTH,
  parameter int HV_WIDTH        = NUM_FOLDS * FOLD_WIDTH,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input logic                clk,
  input logic                rst,
  hv_fold_serializer_if.slave bus
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] TOP_FOLD =
    NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  localparam logic [HC_W-1:0] HOLD_END =
    HC_W'(HOLD_CYCLES - 1);

  fold_state_e                state_q, state_d;
  logic [HC_W-1:0]            hold_q, hold_d;
  logic [FOLD_WIDTH-1:0]      hvout_q, hvout_d;
  logic [NUM_FOLDS_WIDTH-1:0] idx_q, idx_d;
  logic                       last_q, last_d;

  logic                       load;
  logic                       ld_slot;
  logic [NUM_FOLDS_WIDTH-1:0] ld_fold;
  logic                       rel;
  logic                       in_fire;
  logic [FOLD_WIDTH-1:0]      fold_data;
  logic                       rd_ptr;
  logic [1:0]                 count;
  logic                       buf_ready;

  assign in_fire = bus.hvin_valid & buf_ready;

  hv_pingpong_buffer #(
    .NUM_FOLDS_WIDTH(NUM_FOLDS_WIDTH),
    .FOLD_WIDTH     (FOLD_WIDTH),
    .HV_WIDTH       (HV_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (in_fire),
    .wr_data_i(bus.hvin),
    .rel_i    (rel),
    .rd_slot_i(ld_slot),
    .rd_fold_i(ld_fold),
    .rd_data_o(fold_data),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .ready_o  (buf_ready)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    load    = 1'b0;
    ld_slot = rd_ptr;
    ld_fold = TOP_FOLD;
    rel     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count != 2'd0) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.hvout_ready) begin
          // The slot is freed at the last fire, not after hold.
          rel = (idx_q == '0);
          if (HOLD_CYCLES > 1) begin
            state_d = ST_HOLD;
            hold_d  = HC_W'(1);
          end else if (idx_q != '0) begin
            load    = 1'b1;
            ld_fold = idx_q - NUM_FOLDS_WIDTH'(1);
          end else if (count == 2'd2) begin
            load    = 1'b1;
            ld_slot = ~rd_ptr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_END) begin
          hold_d = '0;
          if (idx_q != '0) begin
            load    = 1'b1;
            ld_fold = idx_q - NUM_FOLDS_WIDTH'(1);
            state_d = ST_PRESENT;
          end else if (count != 2'd0) begin
            load    = 1'b1;
            state_d = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    hvout_d = load ? fold_data : hvout_q;
    idx_d   = load ? ld_fold : idx_q;
    last_d  = load ? (ld_fold == '0) : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      hvout_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hvout_q <= hvout_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.hvin_ready  = buf_ready;
  assign bus.hvout_valid = (state_q == ST_PRESENT);
  assign bus.hvout       = hvout_q;
  assign bus.hvout_last  = last_q;
  assign bus.fold_idx    = idx_q;

endmodule

// File: tb/tb_hv_fold_serializer.sv
// Scoreboard bench for hv_fold_serializer: a HOLD_CYCLES=4 build
// and a HOLD_CYCLES=1 build driven from one clock and reset.
module tb_hv_fold_serializer;

  localparam int NF  = 4;
  localparam int FW  = 8;
  localparam int NFW = 2;
  localparam int HW  = NF * FW;

  typedef struct packed {
    logic [FW-1:0]  d;
    logic [NFW-1:0] i;
    logic           l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hv_fold_serializer_if #(
    .HV_WIDTH(HW), .FOLD_WIDTH(FW), .NUM_FOLDS_WIDTH(NFW)
  ) bus_a (), bus_b ();

  hv_fold_serializer #(
    .NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW),
    .FOLD_WIDTH(FW), .HV_WIDTH(HW), .HOLD_CYCLES(4)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus_a));

  hv_fold_serializer #(
    .NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW),
    .FOLD_WIDTH(FW), .HV_WIDTH(HW), .HOLD_CYCLES(1)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus_b));

  exp_t qa[$];
  exp_t qb[$];
  int   fa[$];
  int   fb[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   in_cyc_a = 0;
  int   in_cyc_b = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.hvin_valid && bus_a.hvin_ready) begin
        in_cyc_a = cyc;
        for (int f = NF - 1; f >= 0; f--) begin
          ea.d = bus_a.hvin[f*FW +: FW];
          ea.i = NFW'(f);
          ea.l = (f == 0);
          qa.push_back(ea);
        end
      end
      if (bus_a.hvout_valid && bus_a.hvout_ready) begin
        fa.push_back(cyc);
        if (qa.size() == 0) chk("a_extra", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_data", bus_a.hvout, ea.d);
          chk("a_idx", bus_a.fold_idx, ea.i);
          chk("a_last", bus_a.hvout_last, ea.l);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_b.hvin_valid && bus_b.hvin_ready) begin
        in_cyc_b = cyc;
        for (int f = NF - 1; f >= 0; f--) begin
          eb.d = bus_b.hvin[f*FW +: FW];
          eb.i = NFW'(f);
          eb.l = (f == 0);
          qb.push_back(eb);
        end
      end
      if (bus_b.hvout_valid && bus_b.hvout_ready) begin
        fb.push_back(cyc);
        if (qb.size() == 0) chk("b_extra", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_data", bus_b.hvout, eb.d);
          chk("b_idx", bus_b.fold_idx, eb.i);
          chk("b_last", bus_b.hvout_last, eb.l);
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [HW-1:0] v);
    bit ok = 0;
    if (sel) begin
      bus_b.hvin = v; bus_b.hvin_valid = 1'b1;
    end else begin
      bus_a.hvin = v; bus_a.hvin_valid = 1'b1;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sel ? bus_b.hvin_ready : bus_a.hvin_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(sel ? "b_send_to" : "a_send_to", 0, 1);
    @(posedge clk); #1;
    if (sel) bus_b.hvin_valid = 1'b0;
    else     bus_a.hvin_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    bit ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sel ? (qb.size() == 0 && !bus_b.hvout_valid)
              : (qa.size() == 0 && !bus_a.hvout_valid)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(sel ? "b_drain_to" : "a_drain_to", 0, 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_gaps(input bit sel, input int n,
                            input int gap);
    int sz;
    sz = sel ? fb.size() : fa.size();
    chk(sel ? "b_nfires" : "a_nfires", sz, n);
    for (int i = 1; i < sz; i++) begin
      if (sel) chk("b_gap", fb[i] - fb[i-1], gap);
      else     chk("a_gap", fa[i] - fa[i-1], gap);
    end
  endtask

  initial begin
    bit found;
    bus_a.hvin_valid = 1'b0; bus_a.hvin = '0;
    bus_a.hvout_ready = 1'b1;
    bus_b.hvin_valid = 1'b0; bus_b.hvin = '0;
    bus_b.hvout_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", bus_a.hvout_valid, 0);
    chk("rst_ready", bus_a.hvin_ready, 1);
    chk("rst_hvout", bus_a.hvout, 0);
    chk("rst_idx", bus_a.fold_idx, 0);
    chk("rst_last", bus_a.hvout_last, 0);
    chk("rst_b_ready", bus_b.hvin_ready, 1);

    // single vector, consumer always ready
    fa.delete();
    send(0, 32'hA1B2C3D4);
    wait_drain(0);
    if (fa.size() > 0) chk("t1_lat", fa[0] - in_cyc_a, 2);
    check_gaps(0, 4, 4);
    chk("t1_valid", bus_a.hvout_valid, 0);
    chk("t1_hold", bus_a.hvout, 8'hD4);
    chk("t1_idx", bus_a.fold_idx, 0);
    chk("t1_last", bus_a.hvout_last, 1);

    // back-to-back vectors, third offered while full
    fa.delete();
    send(0, 32'h11223344);
    send(0, 32'h55667788);
    bus_a.hvin = 32'h99AABBCC;
    bus_a.hvin_valid = 1'b1;
    @(negedge clk);
    chk("t2_full", bus_a.hvin_ready, 0);
    send(0, 32'h99AABBCC);
    wait_drain(0);
    check_gaps(0, 12, 4);

    // backpressure while presenting
    bus_a.hvout_ready = 1'b0;
    fa.delete();
    send(0, 32'h0F1E2D3C);
    send(0, 32'h4B5A6978);
    bus_a.hvin = 32'h8796A5B4;
    bus_a.hvin_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_valid", bus_a.hvout_valid, 1);
      chk("t3_hvout", bus_a.hvout, 8'h0F);
      chk("t3_idx", bus_a.fold_idx, 3);
      chk("t3_inrdy", bus_a.hvin_ready, 0);
    end
    @(posedge clk); #1;
    bus_a.hvout_ready = 1'b1;
    send(0, 32'h8796A5B4);
    wait_drain(0);
    chk("t3_nfires", fa.size(), 12);

    // zero-hold build streams one fold per cycle
    fb.delete();
    send(1, 32'hA1B2C3D4);
    wait_drain(1);
    if (fb.size() > 0) chk("t4_lat", fb[0] - in_cyc_b, 2);
    check_gaps(1, 4, 1);

    // last-fold fire and new vector in the same cycle
    bus_a.hvout_ready = 1'b0;
    send(0, 32'h13579BDF);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus_a.hvout_valid && bus_a.fold_idx == 0) begin
        found = 1;
        break;
      end
      bus_a.hvout_ready = bus_a.hvout_valid;
    end
    if (!found) chk("t5_to", 0, 1);
    chk("t5_cnt_pre", u_dut.u_buf.count_q, 1);
    bus_a.hvin = 32'h2468ACE0;
    bus_a.hvin_valid = 1'b1;
    bus_a.hvout_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.hvin_valid = 1'b0;
    chk("t5_cnt_post", u_dut.u_buf.count_q, 1);
    chk("t5_valid", bus_a.hvout_valid, 0);
    wait_drain(0);

    // reset after the second fold has fired
    fa.delete();
    send(0, 32'hFEDCBA98);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fa.size() >= 2) begin
        found = 1;
        break;
      end
    end
    if (!found) chk("t6_to", 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    chk("t6_valid", bus_a.hvout_valid, 0);
    chk("t6_ready", bus_a.hvin_ready, 1);
    chk("t6_hvout", bus_a.hvout, 0);
    chk("t6_idx", bus_a.fold_idx, 0);
    chk("t6_last", bus_a.hvout_last, 0);
    rst = 1'b0;
    fa.delete();
    send(0, 32'hDEADBEEF);
    wait_drain(0);
    chk("t6_nfires", fa.size(), 4);

    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
